mem_burst_ctrl: RTL

- Memory-side controller directly downstream of the CPU top's 64-bit burst memory port (mem_read/mem_write/mem_address/mem_wdata/mem_rdata/mem_resp).
- Converts each 4-beat 256-bit line burst into single-port 64-bit SRAM accesses.
- Inserts a programmable access latency and returns mem_resp once per beat, with the cacheline adaptor's timing.

---
 rtl/mem_ctrl_pkg.sv | 15 +
 rtl/mem_burst_ctrl_if.sv | 29 ++
 rtl/mem_ctrl_sat_cnt.sv | 17 +
 rtl/mem_burst_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the 4-beat line burst memory controller.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      BURST,
      DONE
   } mem_ctrl_state_t;

   localparam int BURST_LEN   = 4;
   localparam int BEAT_W      = 2;
   localparam int LINE_OFFSET = 5;

endpackage

// File: rtl/mem_burst_ctrl_if.sv
// Host-side 64-bit burst memory port between the CPU top and the controller.
interface mem_burst_ctrl_if;

   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_address;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
   logic        mem_resp;

   modport master (
      output mem_read,
      output mem_write,
      output mem_address,
      output mem_wdata,
      input  mem_rdata,
      input  mem_resp
   );

   modport slave (
      input  mem_read,
      input  mem_write,
      input  mem_address,
      input  mem_wdata,
      output mem_rdata,
      output mem_resp
   );

endinterface

// File: rtl/mem_ctrl_sat_cnt.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module mem_ctrl_sat_cnt (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc,
   output logic [31:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 32'd1;
      end
   end

endmodule

// File: rtl/mem_burst_ctrl.sv
// Line burst to 64-bit single-port SRAM controller with programmable latency.
// Define MEM_CTRL_PERF_EN to add saturating read/write/busy counters.
module mem_burst_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int LATENCY = 10,
   parameter int ADDR_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   mem_burst_ctrl_if.slave   bus,
   output logic              sram_en,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [63:0]       sram_wdata,
   input  logic [63:0]       sram_rdata
`ifdef MEM_CTRL_PERF_EN
   ,
   output logic [31:0]       perf_reads,
   output logic [31:0]       perf_writes,
   output logic [31:0]       perf_busy
`endif
);

   localparam int LINE_W = ADDR_W - BEAT_W;
   localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

   mem_ctrl_state_t    state;
   mem_ctrl_state_t    state_nx;
   logic               op_wr;
   logic [LINE_W-1:0]  line;
   logic [7:0]         lat_cnt;
   logic [7:0]         lat_nx;
   logic [BEAT_W-1:0]  beat;
   logic [BEAT_W-1:0]  beat_nx;
   logic [BEAT_W-1:0]  beat_inc;
   logic               req;
   logic               accept;
   logic               resp;
   logic [63:0]        rdata;

   assign req      = bus.mem_read | bus.mem_write;
   assign beat_inc = beat + BEAT_W'(1);

   assign bus.mem_resp  = resp;
   assign bus.mem_rdata = rdata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         op_wr   <= 1'b0;
         line    <= '0;
         lat_cnt <= '0;
         beat    <= '0;
      end else begin
         state   <= state_nx;
         lat_cnt <= lat_nx;
         beat    <= beat_nx;
         if (accept) begin
            op_wr <= bus.mem_write;
            line  <= bus.mem_address[LINE_OFFSET +: LINE_W];
            assert (!(bus.mem_read && bus.mem_write))
               else $warning("mem_burst_ctrl: read and write together, write taken");
         end
      end
   end

   always_comb begin
      state_nx   = state;
      lat_nx     = lat_cnt;
      beat_nx    = beat;
      accept     = 1'b0;
      resp       = 1'b0;
      rdata      = '0;
      sram_en    = 1'b0;
      sram_we    = 1'b0;
      sram_addr  = '0;
      sram_wdata = '0;
      unique case (state)
         IDLE: begin
            if (req) begin
               accept   = 1'b1;
               lat_nx   = LAT_LOAD;
               state_nx = WAIT;
            end
         end
         WAIT: begin
            if (lat_cnt == '0) begin
               state_nx = BURST;
               beat_nx  = '0;
               // Read data must already be in flight when beat 0 starts.
               if (!op_wr) begin
                  sram_en   = 1'b1;
                  sram_addr = {line, {BEAT_W{1'b0}}};
               end
            end else begin
               lat_nx = lat_cnt - 8'd1;
            end
         end
         BURST: begin
            resp = 1'b1;
            if (op_wr) begin
               sram_en    = 1'b1;
               sram_we    = 1'b1;
               sram_addr  = {line, beat};
               sram_wdata = bus.mem_wdata;
            end else begin
               rdata = sram_rdata;
               if (beat != LAST_BEAT) begin
                  sram_en   = 1'b1;
                  sram_addr = {line, beat_inc};
               end
            end
            if (beat == LAST_BEAT) begin
               state_nx = DONE;
            end else begin
               beat_nx = beat_inc;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

`ifdef MEM_CTRL_PERF_EN
   mem_ctrl_sat_cnt u_reads (
      .clk   (clk),
      .rst_n (reset_n),
      .inc   (accept & ~bus.mem_write),
      .count (perf_reads)
   );

   mem_ctrl_sat_cnt u_writes (
      .clk   (clk),
      .rst_n (reset_n),
      .inc   (accept & bus.mem_write),
      .count (perf_writes)
   );

   mem_ctrl_sat_cnt u_busy (
      .clk   (clk),
      .rst_n (reset_n),
      .inc   (state != IDLE),
      .count (perf_busy)
   );
`endif

endmodule
